// File: rtl/message_streamer.sv
// Buffers a host-loaded message and streams it to Mining_FSM as SHA-256 padded 32-bit words,
// one word per cycle while the FSM sits in its write state.
module message_streamer #(
  parameter int          DEPTH_LOG2  = 6,
  parameter logic [2:0]  WRITE_STATE = 3'h1,
  parameter logic [15:0] BASE_ADDR   = 16'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic        clear,
  input  logic [2:0]  fsm_state,
  output logic [31:0] message,
  output logic [15:0] indirizzo,
  output logic [8:0]  indirizzo_width,
  output logic        stopw,
  output logic        busy,
  output logic        overflow
);

  // state | meaning
  // IDLE  | accepting host writes, waiting for start
  // SEND  | emitting padded word k on each write-state edge
  // DONE  | all T words delivered, stopw held until clear

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NW    = DEPTH_LOG2 + 1;
  localparam int KW    = DEPTH_LOG2 + 6;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t         state;
  logic [31:0]    mem [DEPTH];
  logic [NW-1:0]  n_words;
  logic [KW-1:0]  k_idx;
  logic [KW-1:0]  t_total;
  logic [KW-1:0]  n_ext;
  logic [KW-1:0]  t_calc;
  logic [31:0]    word_k;
  logic           mem_we;

  assign n_ext  = KW'(n_words);
  // T = 16*ceil((N+3)/16): data + 0x80 marker + two length words, rounded up to a block
  assign t_calc = (n_ext + KW'(18)) & ~KW'(15);
  assign mem_we = (state == IDLE) && wr_en && !clear && !start && (n_words != NW'(DEPTH));

  always_comb begin
    word_k = 32'h0;
    if (k_idx < n_ext)
      word_k = mem[k_idx[DEPTH_LOG2-1:0]];
    else if (k_idx == n_ext)
      word_k = 32'h8000_0000;
    else if (k_idx == t_total - KW'(1))
      word_k = 32'({n_words, 5'b00000});
  end

  always_ff @(posedge clock) begin
    if (mem_we)
      mem[n_words[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      n_words         <= '0;
      k_idx           <= '0;
      t_total         <= '0;
      message         <= 32'h0;
      indirizzo       <= BASE_ADDR;
      indirizzo_width <= 9'd511;
      stopw           <= 1'b0;
      busy            <= 1'b0;
      overflow        <= 1'b0;
    end else if (clear) begin
      state           <= IDLE;
      n_words         <= '0;
      k_idx           <= '0;
      indirizzo       <= BASE_ADDR;
      indirizzo_width <= 9'd511;
      stopw           <= 1'b0;
      busy            <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            t_total <= t_calc;
            k_idx   <= '0;
            busy    <= 1'b1;
            state   <= SEND;
          end else if (wr_en) begin
            if (n_words == NW'(DEPTH))
              overflow <= 1'b1;
            else
              n_words <= n_words + NW'(1);
          end
        end
        SEND: begin
          if (k_idx == t_total) begin
            stopw <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (fsm_state == WRITE_STATE) begin
            message         <= word_k;
            indirizzo       <= BASE_ADDR + 16'(k_idx >> 4);
            indirizzo_width <= {~k_idx[3:0], 5'b11111};
            k_idx           <= k_idx + KW'(1);
          end
        end
        DONE: begin
          stopw <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_message_streamer.sv
// Randomized directed bench for message_streamer; expected streams come from a padding model
// built from the message queue.
module tb_message_streamer;

  localparam logic [15:0] BASE = 16'h0;
  localparam int          DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        start;
  logic        clear;
  logic [2:0]  fsm_state;
  logic [31:0] message;
  logic [15:0] indirizzo;
  logic [8:0]  indirizzo_width;
  logic        stopw;
  logic        busy;
  logic        overflow;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] msg_q[$];
  logic [31:0] exp_q[$];
  int          idx;
  logic [31:0] last_exp;

  message_streamer #(.DEPTH_LOG2(6), .WRITE_STATE(3'h1), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .clear(clear), .fsm_state(fsm_state), .message(message), .indirizzo(indirizzo),
    .indirizzo_width(indirizzo_width), .stopw(stopw), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_msg"}, message, 32'h0);
    chk({tag, "_addr"}, 32'(indirizzo), 32'(BASE));
    chk({tag, "_width"}, 32'(indirizzo_width), 32'd511);
    chk({tag, "_stopw"}, 32'(stopw), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = $urandom;
      step();
      if (msg_q.size() < DEPTH) msg_q.push_back(wr_data);
    end
    wr_en = 1'b0;
  endtask

  // Padded stream: data, 0x80000000, zeros, length hi (0), length lo (bits)
  task automatic build_exp();
    int n, t;
    n = msg_q.size();
    t = 16 * ((n + 3 + 15) / 16);
    exp_q.delete();
    foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
    exp_q.push_back(32'h8000_0000);
    while (exp_q.size() < t - 1) exp_q.push_back(32'h0);
    exp_q.push_back(32'(n * 32));
  endtask

  task automatic begin_stream();
    build_exp();
    fsm_state = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_stopw", 32'(stopw), 32'd0);
    idx = 0;
  endtask

  // mode 0: always write state, 1: random stalls, 2: toggle every 3 cycles
  task automatic stream_words(input int mode, input int limit);
    int target, cyc;
    target = (limit < 0) ? exp_q.size() : idx + limit;
    cyc = 0;
    while (idx < target && cyc < 3000) begin
      case (mode)
        0:       fsm_state = 3'd1;
        1:       fsm_state = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'd1;
        default: fsm_state = ((cyc / 3) % 2 == 0) ? 3'd1 : 3'd0;
      endcase
      step();
      cyc++;
      if (fsm_state == 3'd1) begin
        chk("word", message, exp_q[idx]);
        chk("addr", 32'(indirizzo), 32'(BASE) + 32'(idx / 16));
        chk("width", 32'(indirizzo_width), 32'(511 - 32 * (idx % 16)));
        last_exp = exp_q[idx];
        idx++;
      end else if (idx > 0) begin
        chk("stall_hold", message, exp_q[idx-1]);
      end
      chk("stopw_low", 32'(stopw), 32'd0);
    end
    chk("stream_budget", 32'(idx), 32'(target));
    fsm_state = 3'd0;
  endtask

  task automatic finish_stream();
    int t;
    t = exp_q.size();
    fsm_state = 3'($urandom_range(0, 1));
    step();
    fsm_state = 3'd0;
    chk("done_stopw", 32'(stopw), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_msg", message, exp_q[t-1]);
    chk("done_addr", 32'(indirizzo), 32'(BASE) + 32'((t - 1) / 16));
    chk("done_width", 32'(indirizzo_width), 32'd31);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    msg_q.delete();
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; clear = 1'b0; fsm_state = 3'd0;
    last_exp = '0;
    #12;
    chk_reset_vals("reset");
    reset = 1'b1;
    step();

    // 1: single word "abcd"
    wr_en = 1'b1; wr_data = 32'h6162_6364; step(); wr_en = 1'b0;
    msg_q.push_back(32'h6162_6364);
    begin_stream();
    stream_words(0, -1);
    chk("t1_len_lo", message, 32'h20);
    finish_stream();
    start = 1'b1; step(); start = 1'b0;
    chk("done_start_stopw", 32'(stopw), 32'd1);
    chk("done_start_busy", 32'(busy), 32'd0);
    do_clear();
    chk("clr_addr", 32'(indirizzo), 32'(BASE));
    chk("clr_width", 32'(indirizzo_width), 32'd511);
    chk("clr_stopw", 32'(stopw), 32'd0);

    // 2: N=14 spills length into a second block
    load(14);
    begin_stream();
    stream_words(1, -1);
    chk("t2_len_lo", message, 32'h1C0);
    chk("t2_addr", 32'(indirizzo), 32'(BASE) + 32'd1);
    finish_stream();
    do_clear();

    // 4: overflow at 65 writes, full 80-word stream
    load(65);
    chk("ovf_set", 32'(overflow), 32'd1);
    begin_stream();
    chk("t4_len", 32'(exp_q.size()), 32'd80);
    stream_words(1, -1);
    finish_stream();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_clear();
    chk("ovf_clr", 32'(overflow), 32'd0);

    // 3: N=0 with fsm_state toggling every 3 cycles
    begin_stream();
    stream_words(2, -1);
    chk("t3_count", 32'(idx), 32'd16);
    finish_stream();
    do_clear();

    // 13-word exact fit
    load(13);
    begin_stream();
    chk("t13_len", 32'(exp_q.size()), 32'd16);
    stream_words(1, -1);
    finish_stream();
    do_clear();

    // 5: async reset mid-stream, then reload and restream
    load(5);
    begin_stream();
    stream_words(0, 10);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    step();
    #3;
    reset = 1'b1;
    msg_q.delete();
    step();
    load(3);
    begin_stream();
    stream_words(1, -1);
    finish_stream();
    do_clear();

    // 6: start during SEND is ignored; clear beats start
    load(2);
    begin_stream();
    stream_words(0, 3);
    start = 1'b1; step(); start = 1'b0;
    chk("send_start_busy", 32'(busy), 32'd1);
    chk("send_start_hold", message, last_exp);
    stream_words(0, -1);
    finish_stream();
    do_clear();
    begin_stream();
    stream_words(0, 2);
    clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
    chk("cs_busy", 32'(busy), 32'd0);
    chk("cs_addr", 32'(indirizzo), 32'(BASE));
    chk("cs_width", 32'(indirizzo_width), 32'd511);
    fsm_state = 3'd1;
    step(); step(); step();
    fsm_state = 3'd0;
    chk("cs_idle_hold", message, last_exp);
    chk("cs_idle_busy", 32'(busy), 32'd0);
    chk("cs_idle_stopw", 32'(stopw), 32'd0);

    // wr_en together with clear: word dropped, so N stays 0
    wr_en = 1'b1; clear = 1'b1; wr_data = $urandom; step(); wr_en = 1'b0; clear = 1'b0;
    msg_q.delete();
    begin_stream();
    chk("wc_len", 32'(exp_q.size()), 32'd16);
    stream_words(0, -1);
    chk("wc_first_zero_len", message, 32'h0);
    finish_stream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
